// File: rtl/frame_buf_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_rd_arbiter
// Brief    : Shares one frame-buffer burst-read port between the VGA refill
//            path (urgent priority) and the AI frame reader (round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module frame_buf_rd_arbiter #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk_out,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic              vga_urgent,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rd_valid,
  output logic [DATA_W-1:0] vga_rd_data,
  input  logic              ai_req,
  input  logic [ADDR_W-1:0] ai_addr,
  output logic              ai_gnt,
  output logic              ai_rd_valid,
  output logic [DATA_W-1:0] ai_rd_data,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              owner,
  output logic              err_stray
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BURST_LEN - 1);

  state_t              r_state,    w_state_nxt;
  logic [CNT_W-1:0]    r_cnt,      w_cnt_nxt;
  logic                r_rr,       w_rr_nxt;
  logic                r_owner,    w_owner_nxt;
  logic [ADDR_W-1:0]   r_cmd_addr, w_cmd_addr_nxt;
  logic                r_vga_gnt,  w_vga_gnt_nxt;
  logic                r_ai_gnt,   w_ai_gnt_nxt;
  logic                r_err_stray, w_err_stray_nxt;
  logic                w_sel_ai;
  logic                w_in_data;

  // r_rr: 0 means VGA is preferred on a non-urgent tie, 1 means AI.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rr        <= 1'b0;
      r_owner     <= 1'b0;
      r_cmd_addr  <= '0;
      r_vga_gnt   <= 1'b0;
      r_ai_gnt    <= 1'b0;
      r_err_stray <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rr        <= w_rr_nxt;
      r_owner     <= w_owner_nxt;
      r_cmd_addr  <= w_cmd_addr_nxt;
      r_vga_gnt   <= w_vga_gnt_nxt;
      r_ai_gnt    <= w_ai_gnt_nxt;
      r_err_stray <= w_err_stray_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rr_nxt        = r_rr;
    w_owner_nxt     = r_owner;
    w_cmd_addr_nxt  = r_cmd_addr;
    w_vga_gnt_nxt   = 1'b0;
    w_ai_gnt_nxt    = 1'b0;
    w_err_stray_nxt = r_err_stray | (mem_rd_valid && (r_state != S_DATA));
    w_sel_ai        = ai_req && !(vga_req && (vga_urgent || !r_rr));

    case (r_state)
      S_IDLE: begin
        if (vga_req || ai_req) begin
          w_owner_nxt    = w_sel_ai;
          w_cmd_addr_nxt = w_sel_ai ? ai_addr : vga_addr;
          w_vga_gnt_nxt  = !w_sel_ai;
          w_ai_gnt_nxt   = w_sel_ai;
          w_state_nxt    = S_CMD;
        end
      end
      S_CMD: begin
        if (mem_cmd_ready) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (mem_rd_valid) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == c_LAST) begin
            w_rr_nxt    = !r_owner;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_in_data     = (r_state == S_DATA);
  assign mem_cmd_valid = (r_state == S_CMD);
  assign mem_cmd_addr  = r_cmd_addr;
  assign busy          = (r_state != S_IDLE);
  assign owner         = r_owner;
  assign err_stray     = r_err_stray;
  assign vga_gnt       = r_vga_gnt;
  assign ai_gnt        = r_ai_gnt;

  // Return beats are steered only while a burst is in flight.
  assign vga_rd_valid  = w_in_data && !r_owner && mem_rd_valid;
  assign ai_rd_valid   = w_in_data &&  r_owner && mem_rd_valid;
  assign vga_rd_data   = (w_in_data && !r_owner) ? mem_rd_data : '0;
  assign ai_rd_data    = (w_in_data &&  r_owner) ? mem_rd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_rd_arbiter.sv
`default_nettype none
// Bench for frame_buf_rd_arbiter: random requesters and memory, a simple
// arbitration model feeding grant/beat queues that a monitor drains.
module tb_frame_buf_rd_arbiter;

  localparam int ADDR_W    = 22;
  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 8;

  logic              clk_out = 1'b0;
  logic              rst_n;
  logic              vga_req, vga_urgent, ai_req;
  logic [ADDR_W-1:0] vga_addr, ai_addr;
  logic              vga_gnt, vga_rd_valid, ai_gnt, ai_rd_valid;
  logic [DATA_W-1:0] vga_rd_data, ai_rd_data;
  logic              mem_cmd_valid, mem_cmd_ready;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;
  logic              busy, owner, err_stray;

  frame_buf_rd_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(4)
  ) dut (
    .clk_out(clk_out), .rst_n(rst_n),
    .vga_req(vga_req), .vga_urgent(vga_urgent), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt), .vga_rd_valid(vga_rd_valid), .vga_rd_data(vga_rd_data),
    .ai_req(ai_req), .ai_addr(ai_addr), .ai_gnt(ai_gnt),
    .ai_rd_valid(ai_rd_valid), .ai_rd_data(ai_rd_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .busy(busy), .owner(owner),
    .err_stray(err_stray)
  );

  always #20 clk_out = ~clk_out;

  int tests = 0;
  int fails = 0;

  // Reference state: who is preferred on a tie, and the expected sticky flag.
  bit pref      = 1'b0;
  bit exp_stray = 1'b0;

  logic [ADDR_W:0]   grant_q[$];   // {who, addr}
  logic [DATA_W:0]   beat_q[$];    // {who, data}
  logic [ADDR_W-1:0] cur_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a beat.
  always @(negedge clk_out) begin
    logic [ADDR_W:0] ge;
    logic [DATA_W:0] be;
    if (rst_n) begin
      if (vga_gnt && ai_gnt) chk("gnt_both", 32'(1), 32'(0));
      if (vga_gnt || ai_gnt) begin
        if (grant_q.size() == 0) chk("gnt_unexpected", 32'(1), 32'(0));
        else begin
          ge = grant_q.pop_front();
          chk("gnt_who", 32'(ai_gnt), 32'(ge[ADDR_W]));
          chk("gnt_owner", 32'(owner), 32'(ge[ADDR_W]));
          chk("cmd_addr", 32'(mem_cmd_addr), 32'(ge[ADDR_W-1:0]));
          cur_addr = ge[ADDR_W-1:0];
        end
      end
      if (mem_cmd_valid) chk("cmd_addr_hold", 32'(mem_cmd_addr), 32'(cur_addr));
      if (vga_rd_valid && ai_rd_valid) chk("rd_valid_both", 32'(1), 32'(0));
      if (vga_rd_valid || ai_rd_valid) begin
        if (beat_q.size() == 0) chk("beat_unexpected", 32'(1), 32'(0));
        else begin
          be = beat_q.pop_front();
          chk("beat_who", 32'(ai_rd_valid), 32'(be[DATA_W]));
          chk("beat_data", 32'(ai_rd_valid ? ai_rd_data : vga_rd_data),
              32'(be[DATA_W-1:0]));
          chk("beat_other_zero", 32'(ai_rd_valid ? vga_rd_data : ai_rd_data), 32'(0));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_out);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 32'(|{vga_gnt, vga_rd_valid, vga_rd_data, ai_gnt, ai_rd_valid,
                    ai_rd_data, mem_cmd_valid, mem_cmd_addr, busy, owner, err_stray}),
        32'(0));
  endtask

  // One burst from request to final beat; abort_at > 0 resets after that beat.
  task automatic run_burst(input bit vr, input bit ar, input bit urg,
                           input logic [ADDR_W-1:0] va, input logic [ADDR_W-1:0] aa,
                           input bit seq, input int rdy_dly, input int gap,
                           input int abort_at);
    bit who;
    bit got;
    logic [DATA_W-1:0] d;
    if (vr && urg)     who = 1'b0;
    else if (vr && ar) who = pref;
    else               who = ar;
    grant_q.push_back({who, who ? aa : va});
    vga_req = vr; ai_req = ar; vga_urgent = urg; vga_addr = va; ai_addr = aa;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      cyc();
      got = vga_gnt | ai_gnt;
    end
    vga_req = 1'b0; ai_req = 1'b0; vga_urgent = 1'b0;
    if (!got) begin
      chk("gnt_timeout", 32'(0), 32'(1));
      grant_q.delete();
      return;
    end
    repeat (rdy_dly) cyc();
    mem_cmd_ready = 1'b1;
    cyc();
    mem_cmd_ready = 1'b0;
    for (int b = 0; b < BURST_LEN; b++) begin
      repeat (gap) cyc();
      d = seq ? DATA_W'(16'hA000 + b) : DATA_W'($urandom);
      mem_rd_valid = 1'b1;
      mem_rd_data  = d;
      beat_q.push_back({who, d});
      cyc();
      mem_rd_valid = 1'b0;
      mem_rd_data  = DATA_W'($urandom);
      if (b == abort_at - 1) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_cmd_valid", 32'(mem_cmd_valid), 32'(0));
        chk("abort_owner", 32'(owner), 32'(0));
        cyc();
        check_all_zero("abort_outputs");
        rst_n = 1'b1;
        pref = 1'b0;
        exp_stray = 1'b0;
        // A leftover in-flight beat after release must be flagged, not routed.
        mem_rd_valid = 1'b1;
        cyc();
        mem_rd_valid = 1'b0;
        exp_stray = 1'b1;
        chk("abort_stray", 32'(err_stray), 32'(exp_stray));
        return;
      end
      if (b == BURST_LEN - 2) chk("busy_mid", 32'(busy), 32'(1));
    end
    chk("busy_end", 32'(busy), 32'(0));
    chk("err_stray", 32'(err_stray), 32'(exp_stray));
    pref = ~who;
  endtask

  initial begin
    bit vr, ar;
    rst_n = 1'b0;
    vga_req = 0; vga_urgent = 0; ai_req = 0; vga_addr = '0; ai_addr = '0;
    mem_cmd_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
    repeat (3) cyc();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_all_zero("idle_outputs");
    end

    // Ties with no urgency: VGA, AI, VGA, AI.
    for (int i = 0; i < 4; i++)
      run_burst(1, 1, 0, ADDR_W'($urandom), ADDR_W'($urandom), 0, 0, 0, 0);

    // Directed VGA burst with immediate accept.
    run_burst(1, 0, 0, 22'h000100, 22'h0, 1, 0, 0, 0);
    // Urgent tie keeps VGA, then a plain tie goes to AI.
    run_burst(1, 1, 1, ADDR_W'($urandom), ADDR_W'($urandom), 0, 1, 0, 0);
    run_burst(1, 1, 0, ADDR_W'($urandom), ADDR_W'($urandom), 0, 0, 0, 0);

    // Command backpressure and gaps between beats.
    run_burst(0, 1, 0, ADDR_W'($urandom), ADDR_W'($urandom), 0, 5, 1, 0);

    // Stray beat in IDLE, then confirm it sticks across a burst.
    mem_rd_valid = 1'b1;
    mem_rd_data  = DATA_W'($urandom);
    cyc();
    mem_rd_valid = 1'b0;
    exp_stray = 1'b1;
    chk("stray_idle", 32'(err_stray), 32'(1));
    run_burst(1, 0, 0, ADDR_W'($urandom), ADDR_W'($urandom), 0, 2, 0, 0);

    // Reset in the middle of an AI burst after beat 3.
    run_burst(0, 1, 0, ADDR_W'($urandom), ADDR_W'($urandom), 0, 1, 0, 3);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      vr = 1'($urandom);
      ar = 1'($urandom);
      if (!vr && !ar) ar = 1'b1;
      run_burst(vr, ar, 1'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), 0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0);
      repeat ($urandom_range(0, 2)) cyc();
    end

    repeat (3) cyc();
    chk("grant_q_empty", 32'(grant_q.size()), 32'(0));
    chk("beat_q_empty", 32'(beat_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(40 * 20000);
    fails++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/frame_buf_rd_arbiter.md
Name: frame_buf_rd_arbiter

Overview:
- Schedules a single shared frame-buffer read port (burst command plus return-data channel) between two requesters.
- Requester 0 is the VGA line refill path, which feeds the pixel FIFO drained by the display interface.
- Requester 1 is the edge-AI analytics frame reader.
- The VGA path is hard real-time and gets absolute priority when it flags urgency; otherwise the two requesters alternate round-robin, one fixed-length burst at a time.
- Runs in the 25 MHz VGA pixel clock domain.

Parameters:
- ADDR_W, 22, word address width of the frame buffer.
- DATA_W, 16, pixel word width (RGB565).
- BURST_LEN, 8, read beats per granted burst; must be at least 1.
- CNT_W, 4, beat counter width; must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk_out  in  1  VGA pixel clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- vga_req  in  1  VGA path requests one burst.
- vga_urgent  in  1  VGA pixel FIFO is below its low watermark.
- vga_addr  in  ADDR_W  VGA burst start address.
- vga_gnt  out  1  one-cycle grant pulse to VGA.
- vga_rd_valid  out  1  return beat for VGA.
- vga_rd_data  out  DATA_W  return data for VGA.
- ai_req  in  1  AI reader requests one burst.
- ai_addr  in  ADDR_W  AI burst start address.
- ai_gnt  out  1  one-cycle grant pulse to AI.
- ai_rd_valid  out  1  return beat for AI.
- ai_rd_data  out  DATA_W  return data for AI.
- mem_cmd_valid  out  1  burst read command valid.
- mem_cmd_ready  in  1  memory accepts the command.
- mem_cmd_addr  out  ADDR_W  burst start address.
- mem_rd_valid  in  1  memory return beat valid.
- mem_rd_data  in  DATA_W  memory return data.
- busy  out  1  a burst is in flight (state not IDLE).
- owner  out  1  current or last grant owner; 0 = VGA, 1 = AI.
- err_stray  out  1  sticky flag: a return beat arrived while in IDLE or CMD.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk_out. On reset:
  - state = IDLE; beat counter = 0.
  - Round-robin pointer = VGA; owner = 0.
  - All outputs are 0, including err_stray and the data outputs.
- Reset asserted mid-burst aborts the burst immediately. Any in-flight beats arriving after release are counted as stray.
- State machine:
  - IDLE: arbitrate on each edge.
    - If vga_req && vga_urgent, VGA wins.
    - Else if only one request is present, that requester wins.
    - Else if both are present, the round-robin pointer decides.
    - On a win: latch the winner into owner, latch its address into mem_cmd_addr, register a one-cycle gnt pulse for the winner, and go to CMD.
    - With no request, stay in IDLE.
  - CMD: hold mem_cmd_valid = 1 with a stable mem_cmd_addr until the cycle in which mem_cmd_ready = 1. Then clear mem_cmd_valid, clear the beat counter, and go to DATA.
  - DATA:
    - Each mem_rd_valid beat increments the counter.
    - Data routing is combinational: owner_rd_valid = mem_rd_valid in DATA state only; owner_rd_data = mem_rd_data. The non-owner's valid stays 0 and its data is driven to 0.
    - The cycle carrying beat BURST_LEN returns to IDLE and sets the round-robin pointer to the non-owner.
    - Gaps between beats are allowed, and the FSM has no timeout.
- Latency:
  - Request sampled at edge n gives gnt high and mem_cmd_valid high in cycle n+1.
  - The earliest re-arbitration is the edge after the final beat.
- Requester contract: hold req and addr stable until gnt. Deassert or update req in the cycle after gnt if no further burst is wanted. Requests seen during CMD or DATA are ignored until IDLE.
- Urgency override: a VGA urgent win does not move the round-robin pointer toward AI beyond the normal post-burst update. AI therefore wins the next non-urgent tie.
- Stray beat: mem_rd_valid in IDLE or CMD sets err_stray (sticky until reset). The beat is dropped and not routed.
- Simultaneous final beat and new request: the final beat finishes the burst in that cycle. The new request is arbitrated at the following IDLE edge.
- mem_cmd_ready in the same cycle mem_cmd_valid first rises is a legal single-cycle accept.

Test Plan:
- Reset then idle: no requests for 20 cycles, so all outputs are 0 and busy = 0. Assert rst_n = 0 mid-DATA at beat 3 → next edge shows busy = 0, mem_cmd_valid = 0, owner = 0.
- Single VGA burst: vga_req = 1, vga_addr = 0x000100, mem_cmd_ready = 1 → vga_gnt pulses one cycle, mem_cmd_addr = 0x000100. 8 beats of 0xA000..0xA007 appear on vga_rd_valid/data. ai_rd_valid stays 0 and busy drops after beat 8.
- Round-robin tie: vga_req = ai_req = 1 held for 4 bursts with no urgency → grant order VGA, AI, VGA, AI, and owner toggles accordingly.
- Urgency override: after a VGA burst, assert both requests plus vga_urgent = 1 → VGA is granted again. Drop urgency → AI wins the next tie.
- Backpressure and gaps: hold mem_cmd_ready = 0 for 5 cycles → mem_cmd_valid and mem_cmd_addr stay stable. Then deliver beats with one idle cycle between each → all 8 beats are routed and the FSM returns to IDLE only after beat 8.
- Stray beat: pulse mem_rd_valid while in IDLE → err_stray = 1 and persists across later bursts. No requester rd_valid is asserted.
